codec_cmd_arbiter: RTL and testbench

CODEC_CMD_ARBITER -- requirements
Module: codec_cmd_arbiter

---
 rtl/codec_cmd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_codec_cmd_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : codec_cmd_arbiter
//  Description : Round-robin arbiter that serialises register writes from
//                three requesters onto the single manual-write port of the
//                codec-init block. A four-state FSM (IDLE/SEND/WAIT/DONE)
//                latches the winning request, strobes manualSend and returns
//                a one-cycle ack to the winner once manualDone arrives.
//                Optional WAIT timeout enabled by macro CODEC_CMD_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module codec_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        initDone,
    input  logic [2:0]  req,
    input  logic [20:0] reqReg,
    input  logic [26:0] reqData,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic [2:0]  grant,
    output logic        manualSend,
    output logic [6:0]  manualRegister,
    output logic [8:0]  manualData,
    input  logic        manualDone,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_last,  w_last_nxt;
    logic [1:0] r_win,   w_win_nxt;
    logic [2:0] r_grant, w_grant_nxt;
    logic [2:0] r_ack,   w_ack_nxt;
    logic       r_send,  w_send_nxt;
    logic       r_busy,  w_busy_nxt;
    logic [6:0] r_reg,   w_reg_nxt;
    logic [8:0] r_data,  w_data_nxt;
    logic [1:0] w_pick;
    logic [6:0] w_pick_reg;
    logic [8:0] w_pick_data;

`ifdef CODEC_CMD_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [2:0]         r_err, w_err_nxt;
    logic [c_TMO_W-1:0] r_tmo, w_tmo_nxt;
`endif

    // Round-robin pick: first active requester searching from last+1 upward
    always_comb begin
        case (r_last)
            2'd0:    w_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Select the register/data slice belonging to the picked requester
    always_comb begin
        case (w_pick)
            2'd1:    begin w_pick_reg = reqReg[13:7];  w_pick_data = reqData[17:9];  end
            2'd2:    begin w_pick_reg = reqReg[20:14]; w_pick_data = reqData[26:18]; end
            default: begin w_pick_reg = reqReg[6:0];   w_pick_data = reqData[8:0];   end
        endcase
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_win_nxt   = r_win;
        w_grant_nxt = r_grant;
        w_reg_nxt   = r_reg;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_ack_nxt   = 3'b000;
        w_send_nxt  = 1'b0;
`ifdef CODEC_CMD_TIMEOUT_EN
        w_err_nxt   = 3'b000;
        w_tmo_nxt   = r_tmo;
`endif
        case (r_state)
            ST_IDLE: begin
                if (initDone && (req != 3'b000)) begin
                    w_win_nxt   = w_pick;
                    w_grant_nxt = 3'b001 << w_pick;
                    w_reg_nxt   = w_pick_reg;
                    w_data_nxt  = w_pick_data;
                    w_send_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT;
`ifdef CODEC_CMD_TIMEOUT_EN
                w_tmo_nxt   = '0;
`endif
            end
            ST_WAIT: begin
                if (manualDone) begin
                    w_ack_nxt   = r_grant;
                    w_state_nxt = ST_DONE;
                end
`ifdef CODEC_CMD_TIMEOUT_EN
                else if (r_tmo == c_TMO_LAST) begin
                    // Codec never answered: complete anyway, flagged as error
                    w_ack_nxt   = r_grant;
                    w_err_nxt   = r_grant;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tmo_nxt   = r_tmo + 1'b1;
                end
`endif
            end
            default: begin
                w_grant_nxt = 3'b000;
                w_busy_nxt  = 1'b0;
                w_last_nxt  = r_win;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd2;
            r_win   <= 2'd0;
            r_grant <= 3'b000;
            r_ack   <= 3'b000;
            r_send  <= 1'b0;
            r_busy  <= 1'b0;
            r_reg   <= 7'd0;
            r_data  <= 9'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_win   <= w_win_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_send  <= w_send_nxt;
            r_busy  <= w_busy_nxt;
            r_reg   <= w_reg_nxt;
            r_data  <= w_data_nxt;
        end
    end

`ifdef CODEC_CMD_TIMEOUT_EN
    // Timeout counter and error pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
            r_err <= 3'b000;
        end else begin
            r_tmo <= w_tmo_nxt;
            r_err <= w_err_nxt;
        end
    end
    assign err = r_err;
`else
    assign err = 3'b000;
`endif

    assign ack            = r_ack;
    assign grant          = r_grant;
    assign manualSend     = r_send;
    assign manualRegister = r_reg;
    assign manualData     = r_data;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_codec_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codec_cmd_arbiter
//  Description : Scoreboard bench for codec_cmd_arbiter. Stimulus pushes the
//                expected transaction (grant, register, data, err, ack
//                latency) as it raises requests; a monitor pops and compares
//                when the DUT strobes manualSend / ack. A codec responder
//                answers manualSend with manualDone after a set delay.
//                Timeout scenario runs when CODEC_CMD_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_codec_cmd_arbiter;

    localparam int c_TMO = 16;
    localparam logic [6:0] c_R0 = 7'h11, c_R1 = 7'h04, c_R2 = 7'h6C;
    localparam logic [8:0] c_D0 = 9'h0A5, c_D1 = 9'h012, c_D2 = 9'h1F3;

    logic        clk, rst, initDone, manualDone;
    logic [2:0]  req, ack, err, grant;
    logic [20:0] reqReg;
    logic [26:0] reqData;
    logic        manualSend, busy;
    logic [6:0]  manualRegister;
    logic [8:0]  manualData;

    typedef struct {
        logic [2:0] g;
        logic [6:0] r;
        logic [8:0] d;
        logic [2:0] e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_bad = 0;
    int   done_delay = 3;
    int   cyc = 0, send_cyc = 0, last_ack_cyc = -10;
    bit   in_txn = 0, prev_send = 0, prev_ack = 0;

    codec_cmd_arbiter #(.TIMEOUT_CYCLES(c_TMO)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .initDone       (initDone),
        .req            (req),
        .reqReg         (reqReg),
        .reqData        (reqData),
        .ack            (ack),
        .err            (err),
        .grant          (grant),
        .manualSend     (manualSend),
        .manualRegister (manualRegister),
        .manualData     (manualData),
        .manualDone     (manualDone),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [2:0] g, input logic [6:0] r, input logic [8:0] d,
                            input logic [2:0] e, input int lat);
        exp_t x;
        x.g = g; x.r = r; x.d = d; x.e = e; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic wait_send(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (manualSend) break;
        end
        chk("send_wait", manualSend, 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Codec model: answer each manualSend after done_delay cycles (<0: never)
    initial begin
        manualDone = 1'b0;
        forever begin
            @(negedge clk);
            if (manualSend && done_delay >= 0) begin
                repeat (done_delay) @(negedge clk);
                manualDone = 1'b1;
                @(negedge clk);
                manualDone = 1'b0;
            end
        end
    end

    // Monitor: sample just after each rising edge and score against the queue
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (in_txn && !manualSend && sb.size() > 0) begin
                chk("reg_stable", manualRegister, sb[0].r);
                chk("data_stable", manualData, sb[0].d);
            end
            if (prev_send) chk("send_pulse", manualSend, 0);
            if (prev_ack)  chk("ack_pulse", ack, 0);
            if (ack == 3'b000) chk("err_idle", err, 0);
            if (manualSend) begin
                if (sb.size() == 0) begin
                    chk("unexp_send", manualSend, 0);
                end else begin
                    chk("grant", grant, sb[0].g);
                    chk("send_reg", manualRegister, sb[0].r);
                    chk("send_data", manualData, sb[0].d);
                    chk("send_busy", busy, 1);
                    chk("spacing", (cyc - last_ack_cyc) >= 2, 1);
                    send_cyc = cyc;
                    in_txn   = 1;
                end
            end
            if (ack != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexp_ack", ack, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack", ack, e.g);
                    chk("err", err, e.e);
                    chk("ack_lat", cyc - send_cyc, e.lat);
                    if (e.e == 3'b000) chk("ack_after_done", manualDone, 1);
                    in_txn = 0;
                end
                last_ack_cyc = cyc;
            end
            prev_send = manualSend;
            prev_ack  = (ack != 3'b000);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        initDone = 1'b0;
        req      = 3'b000;
        reqReg   = {c_R2, c_R1, c_R0};
        reqData  = {c_D2, c_D1, c_D0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_send", manualSend, 0);
        chk("rst_reg", manualRegister, 0);
        chk("rst_data", manualData, 0);
        rst = 1'b1;

        // No grants while codec init is incomplete, then exactly one cycle later
        req = 3'b001;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("noinit_busy", busy, 0);
        end
        done_delay = 3;
        push_exp(3'b001, c_R0, c_D0, 3'b000, 4);
        initDone = 1'b1;
        @(posedge clk);
        #1;
        chk("init_send_lat", manualSend, 1);
        wait_drain(40);
        req = 3'b000;

        // Single write from requester 1; inputs disturbed after capture
        done_delay = 20;
        push_exp(3'b010, c_R1, c_D1, 3'b000, 21);
        req = 3'b010;
        wait_send(10);
        req      = 3'b000;
        initDone = 1'b0;
        reqReg   = ~{c_R2, c_R1, c_R0};
        reqData  = ~{c_D2, c_D1, c_D0};
        wait_drain(60);
        repeat (5) @(negedge clk);
        initDone = 1'b1;
        reqReg   = {c_R2, c_R1, c_R0};
        reqData  = {c_D2, c_D1, c_D0};

        // Requester 2 alone
        done_delay = 3;
        push_exp(3'b100, c_R2, c_D2, 3'b000, 4);
        req = 3'b100;
        wait_drain(40);
        req = 3'b000;

        // All three held: rotation 0,1,2,0
        done_delay = 2;
        push_exp(3'b001, c_R0, c_D0, 3'b000, 3);
        push_exp(3'b010, c_R1, c_D1, 3'b000, 3);
        push_exp(3'b100, c_R2, c_D2, 3'b000, 3);
        push_exp(3'b001, c_R0, c_D0, 3'b000, 3);
        req = 3'b111;
        wait_drain(100);
        req = 3'b000;

        // Stray manualDone while idle must be ignored
        repeat (2) @(negedge clk);
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
        @(posedge clk);
        #1;
        chk("stray_done_ack", ack, 0);

        // Reset during WAIT, then requester 0 favoured again
        done_delay = -1;
        push_exp(3'b001, c_R0, c_D0, 3'b000, 0);
        req = 3'b001;
        wait_send(10);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_send", manualSend, 0);
        chk("arst_reg", manualRegister, 0);
        chk("arst_data", manualData, 0);
        sb.delete();
        in_txn     = 0;
        req        = 3'b101;
        done_delay = 2;
        repeat (2) @(negedge clk);
        push_exp(3'b001, c_R0, c_D0, 3'b000, 3);
        push_exp(3'b100, c_R2, c_D2, 3'b000, 3);
        rst = 1'b1;
        wait_drain(60);
        req = 3'b000;

`ifdef CODEC_CMD_TIMEOUT_EN
        // Codec never answers: ack and err together after the timeout
        done_delay = -1;
        push_exp(3'b010, c_R1, c_D1, 3'b010, c_TMO + 1);
        req = 3'b010;
        wait_drain(100);
        req = 3'b000;
`endif

        repeat (5) @(negedge clk);
        chk("final_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
